lfsr_generator: RTL and testbench

- Parallel PRBS source for link and loopback testing. Emits DATA_WIDTH-bit words from a Fibonacci LFSR that advances one bit per accepted word.
- For the same parameters, the stream is bit-compatible with our LFSR checker: word = {lfsr[DATA_WIDTH-2:0], next_bit}.
- Provides seed load, valid/ready output, single-word error injection and statistics counters.
- Sits on the TX side of ADC/DAC/SerDes test paths.

---
 rtl/lfsr_generator_if.sv | 33 +++
 rtl/lfsr_generator.sv | 108 ++++++++++
 tb/tb_lfsr_generator.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_generator_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_generator_if
// Description : Control, handshake and statistics bundle of the PRBS generator.
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_generator_if #(
    parameter int DATA_WIDTH = 14,
    parameter int LFSR_LEN   = 23,
    parameter int STAT_WIDTH = 32
);
    logic                  en;
    logic [LFSR_LEN-1:0]   seed_i;
    logic                  inj_i;
    logic                  ready_i;
    logic                  valid_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [STAT_WIDTH-1:0] word_cnt_o;
    logic [STAT_WIDTH-1:0] inj_cnt_o;
    logic                  busy_o;

    // The generator is the slave; whoever drives en/seed/ready is the master.
    modport master (
        output en, seed_i, inj_i, ready_i,
        input  valid_o, data_o, word_cnt_o, inj_cnt_o, busy_o
    );

    modport slave (
        input  en, seed_i, inj_i, ready_i,
        output valid_o, data_o, word_cnt_o, inj_cnt_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/lfsr_generator.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_generator
// Description : Fibonacci-LFSR PRBS word source with seed load, valid/ready
//               output, single-word error injection and statistics counters.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_generator #(
    parameter int                  DATA_WIDTH = 14,
    parameter int                  LFSR_LEN   = 23,
    parameter logic [LFSR_LEN-1:0] LFSR_POLY  = 23'b100_0010_0000_0000_0000_0000,
    parameter logic                XOR_CONST  = 1'b0,
    parameter logic [LFSR_LEN-1:0] SEED       = 23'h7FFFFF,
    parameter int                  STAT_WIDTH = 32,
    parameter int                  INJ_BIT    = 0
) (
    input  wire logic        clk,
    input  wire logic        rst,
    lfsr_generator_if.slave  bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEED = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    logic [1:0]            state;
    logic [LFSR_LEN-1:0]   lfsr;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  inj_pend;
    logic [STAT_WIDTH-1:0] word_cnt;
    logic [STAT_WIDTH-1:0] inj_cnt;

    logic                  next_bit;
    logic                  load;
    logic                  inj_eff;
    logic [DATA_WIDTH-1:0] inj_mask;
    logic [LFSR_LEN-1:0]   seed_eff;

    assign next_bit = (^(lfsr & LFSR_POLY)) ^ XOR_CONST;
    assign load     = !valid || bus.ready_i;
    assign inj_eff  = bus.inj_i || inj_pend;

    // An all-XOR_CONST register would never leave the lock-up state.
    assign seed_eff = (bus.seed_i == {LFSR_LEN{XOR_CONST}}) ? SEED : bus.seed_i;

    always_comb begin
        inj_mask          = '0;
        inj_mask[INJ_BIT] = inj_eff;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            lfsr     <= '0;
            data     <= '0;
            valid    <= 1'b0;
            inj_pend <= 1'b0;
            word_cnt <= '0;
            inj_cnt  <= '0;
        end else if (!bus.en) begin
            // A word still pending on the output is dropped and never counted.
            state    <= ST_IDLE;
            valid    <= 1'b0;
            inj_pend <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state    <= ST_SEED;
                    word_cnt <= '0;
                    inj_cnt  <= '0;
                    inj_pend <= 1'b0;
                end
                ST_SEED: begin
                    lfsr  <= seed_eff;
                    state <= ST_RUN;
                end
                ST_RUN: begin
                    if (valid && bus.ready_i) begin
                        word_cnt <= word_cnt + STAT_WIDTH'(1);
                    end
                    if (load) begin
                        lfsr  <= {lfsr[LFSR_LEN-2:0], next_bit};
                        data  <= {lfsr[DATA_WIDTH-2:0], next_bit} ^ inj_mask;
                        valid <= 1'b1;
                        if (inj_eff) begin
                            inj_pend <= 1'b0;
                            inj_cnt  <= inj_cnt + STAT_WIDTH'(1);
                        end
                    end else if (bus.inj_i) begin
                        inj_pend <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.valid_o    = valid;
    assign bus.data_o     = data;
    assign bus.word_cnt_o = word_cnt;
    assign bus.inj_cnt_o  = inj_cnt;
    assign bus.busy_o     = (state == ST_SEED) || (state == ST_RUN);

endmodule
`default_nettype wire

// File: tb/tb_lfsr_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_generator
// Description : Scoreboard bench for lfsr_generator with default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_generator;

    logic clk;
    logic rst;

    lfsr_generator_if #(.DATA_WIDTH(14), .LFSR_LEN(23), .STAT_WIDTH(32)) bus ();

    lfsr_generator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks;
    int          errors;
    logic [13:0] q[$];
    logic [13:0] exp_w;

    // Reference: taps 23 and 18 (bit indices 22 and 17), XOR form.
    function automatic logic [22:0] adv(input logic [22:0] s);
        return {s[21:0], s[22] ^ s[17]};
    endfunction

    task automatic push_words(input logic [22:0] seed, input int n, input int flip_idx);
        logic [22:0] s;
        logic [13:0] w;
        s = seed;
        for (int i = 0; i < n; i++) begin
            s = adv(s);
            w = s[13:0];
            if (i == flip_idx) w[0] = ~w[0];
            q.push_back(w);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.en      = 1'b0;
        bus.inj_i   = 1'b0;
        bus.ready_i = 1'b0;
        bus.seed_i  = '0;
        tick();
        tick();
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.valid_o); end
        checks++;
        if (bus.data_o !== 14'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", bus.data_o); end
        checks++;
        if (bus.word_cnt_o !== 32'd0 || bus.inj_cnt_o !== 32'd0) begin
            errors++; $display("FAIL reset_counters: got %0d/%0d want 0/0", bus.word_cnt_o, bus.inj_cnt_o);
        end
        checks++;
        if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy_o); end
    endtask

    task automatic test_seed();
        int lat;
        int cyc;
        do_reset();
        push_words(23'h000001, 20, -1);
        bus.seed_i  = 23'h000001;
        bus.ready_i = 1'b1;
        bus.en      = 1'b1;
        lat = 0;
        while (!bus.valid_o && lat < 10) begin
            tick();
            lat++;
            if (lat == 1) begin
                checks++;
                if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL seed_busy: got %b want 1", bus.busy_o); end
            end
        end
        checks++;
        if (lat != 3) begin errors++; $display("FAIL seed_latency: got %0d want 3", lat); end
        cyc = 0;
        while (q.size() > 0 && cyc < 50) begin
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                checks++;
                if (bus.data_o !== exp_w) begin errors++; $display("FAIL seed_word: got %h want %h", bus.data_o, exp_w); end
            end
            tick();
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL seed_drain: got %0d left want 0", q.size()); end
        checks++;
        if (bus.word_cnt_o !== 32'd20) begin errors++; $display("FAIL seed_word_cnt: got %0d want 20", bus.word_cnt_o); end
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_lockup();
        int cyc;
        do_reset();
        push_words(23'h7FFFFF, 6, -1);
        bus.seed_i  = 23'h000000;
        bus.ready_i = 1'b1;
        bus.en      = 1'b1;
        cyc = 0;
        while (!bus.valid_o && cyc < 10) begin tick(); cyc++; end
        checks++;
        if (bus.data_o !== 14'h3FFE) begin errors++; $display("FAIL lockup_first: got %h want 3ffe", bus.data_o); end
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                checks++;
                if (bus.data_o !== exp_w) begin errors++; $display("FAIL lockup_word: got %h want %h", bus.data_o, exp_w); end
            end
            tick();
            cyc++;
        end
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        int hs;
        int bad;
        do_reset();
        push_words(23'h5A5A5A, 1000, -1);
        bus.seed_i = 23'h5A5A5A;
        bus.en     = 1'b1;
        hs  = 0;
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            bus.ready_i = 1'($urandom_range(0, 1));
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                hs++;
                checks++;
                if (bus.data_o !== exp_w) begin
                    errors++;
                    bad++;
                    if (bad < 5) $display("FAIL bp_word: got %h want %h at handshake %0d", bus.data_o, exp_w, hs);
                end
            end
            tick();
        end
        checks++;
        if (hs < 100) begin errors++; $display("FAIL bp_progress: got %0d handshakes want >= 100", hs); end
        checks++;
        if (bus.word_cnt_o !== 32'(hs)) begin errors++; $display("FAIL bp_word_cnt: got %0d want %0d", bus.word_cnt_o, hs); end
        bus.ready_i = 1'b0;
        bus.en      = 1'b0;
        tick();
    endtask

    task automatic test_injection();
        int cyc;
        do_reset();
        push_words(23'h01ACE5, 10, 1);
        bus.seed_i  = 23'h01ACE5;
        bus.ready_i = 1'b0;
        bus.en      = 1'b1;
        cyc = 0;
        while (!bus.valid_o && cyc < 10) begin tick(); cyc++; end
        bus.inj_i = 1'b1;
        repeat (3) tick();
        bus.inj_i = 1'b0;
        checks++;
        if (bus.inj_cnt_o !== 32'd0) begin errors++; $display("FAIL inj_pending_cnt: got %0d want 0", bus.inj_cnt_o); end
        bus.ready_i = 1'b1;
        cyc = 0;
        while (q.size() > 0 && cyc < 30) begin
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                checks++;
                if (bus.data_o !== exp_w) begin errors++; $display("FAIL inj_word: got %h want %h", bus.data_o, exp_w); end
            end
            tick();
            cyc++;
        end
        checks++;
        if (bus.inj_cnt_o !== 32'd1) begin errors++; $display("FAIL inj_cnt: got %0d want 1", bus.inj_cnt_o); end
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_loopback();
        int ber;
        int other;
        int cyc;
        do_reset();
        push_words(23'h000003, 1600, -1);
        bus.seed_i  = 23'h000003;
        bus.ready_i = 1'b1;
        bus.en      = 1'b1;
        ber   = 0;
        other = 0;
        cyc   = 0;
        while (q.size() > 0 && cyc < 1600) begin
            if (bus.valid_o) begin
                exp_w = q.pop_front();
                if ((bus.data_o ^ exp_w) == 14'h0001) ber++;
                else if (bus.data_o !== exp_w) other++;
            end
            bus.inj_i = (cyc % 200 == 0) && (cyc >= 200) && (cyc <= 1000);
            tick();
            bus.inj_i = 1'b0;
            cyc++;
        end
        checks++;
        if (ber != 5) begin errors++; $display("FAIL loop_ber: got %0d want 5", ber); end
        checks++;
        if (other != 0) begin errors++; $display("FAIL loop_sync: got %0d bad words want 0", other); end
        checks++;
        if (bus.inj_cnt_o !== 32'd5) begin errors++; $display("FAIL loop_inj_cnt: got %0d want 5", bus.inj_cnt_o); end
        bus.en = 1'b0;
        tick();
    endtask

    task automatic test_en_drop();
        int popped;
        int cyc;
        do_reset();
        push_words(23'h000001, 51, -1);
        bus.seed_i  = 23'h000001;
        bus.ready_i = 1'b1;
        bus.en      = 1'b1;
        popped = 0;
        cyc    = 0;
        while (popped < 50 && cyc < 80) begin
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                popped++;
                checks++;
                if (bus.data_o !== exp_w) begin errors++; $display("FAIL drop_word: got %h want %h", bus.data_o, exp_w); end
            end
            tick();
            cyc++;
        end
        exp_w  = q.pop_front();
        bus.en = 1'b0;
        tick();
        checks++;
        if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b want 0", bus.valid_o); end
        checks++;
        if (bus.word_cnt_o !== 32'd50) begin errors++; $display("FAIL drop_word_cnt: got %0d want 50", bus.word_cnt_o); end
        checks++;
        if (bus.data_o !== exp_w || bus.busy_o !== 1'b0) begin
            errors++; $display("FAIL drop_hold: got data %h busy %b want %h busy 0", bus.data_o, bus.busy_o, exp_w);
        end
        q.delete();
        push_words(23'h000001, 5, -1);
        bus.en = 1'b1;
        tick();
        checks++;
        if (bus.word_cnt_o !== 32'd0) begin errors++; $display("FAIL restart_cnt: got %0d want 0", bus.word_cnt_o); end
        cyc = 0;
        while (q.size() > 0 && cyc < 20) begin
            if (bus.valid_o && bus.ready_i) begin
                exp_w = q.pop_front();
                checks++;
                if (bus.data_o !== exp_w) begin errors++; $display("FAIL restart_word: got %h want %h", bus.data_o, exp_w); end
            end
            tick();
            cyc++;
        end
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL restart_drain: got %0d left want 0", q.size()); end
    endtask

    task automatic test_mid_reset();
        rst = 1'b1;
        tick();
        checks++;
        if (bus.valid_o !== 1'b0 || bus.data_o !== 14'h0 || bus.word_cnt_o !== 32'd0 || bus.busy_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got valid %b data %h cnt %0d busy %b want 0 0000 0 0",
                     bus.valid_o, bus.data_o, bus.word_cnt_o, bus.busy_o);
        end
        rst    = 1'b0;
        bus.en = 1'b0;
        tick();
    endtask

    initial begin
        clk    = 1'b0;
        checks = 0;
        errors = 0;
        test_reset();
        test_seed();
        test_lockup();
        test_backpressure();
        test_injection();
        test_loopback();
        test_en_drop();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
